// File: rtl/adder_multiword_seq.sv
// -----------------------------------------------------------------------------
// adder_multiword_seq
//   Multi-cycle wide adder. A W-bit operand pair (W = CHUNK*CHUNKS) is accepted
//   under a valid/ready handshake. It is then pushed through a single 16-bit
//   prefix adder one chunk per cycle, LSB chunk first. The carry out of each
//   chunk feeds the carry in of the next chunk on the following cycle. The
//   assembled W-bit sum and the final carry are returned under a valid/ready
//   handshake.
//
//   Optional feature: define ADDER_SEQ_OVF_EN to add the `ovf` output. It
//   reports signed overflow of the W-bit add.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   block can accept operands (IDLE, or DONE with out_ready)
//   a_in       in   W   operand A
//   b_in       in   W   operand B
//   cin        in   1   carry into bit 0
//   out_valid  out  1   result valid (state DONE)
//   out_ready  in   1   consumer accepts the result
//   sum_out    out  W   A+B+cin, truncated to W bits
//   cout_out   out  1   carry out of bit W-1
//   busy       out  1   state is not IDLE
//   ovf        out  1   signed overflow (only with ADDER_SEQ_OVF_EN)
// -----------------------------------------------------------------------------

// 16-bit Kogge-Stone prefix adder, purely combinational.
module adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] carry_bits;  // carry_bits[i] = carry out of bit i

  // NOTE: always_comb uses blocking assignments. Each prefix level reads the
  // value that the previous loop iteration just produced.
  always_comb begin
    g = a & b;
    p = a ^ b;
    // Each level merges the group spanning distance d below each bit. Bits below
    // d have no partner, so g is left unchanged and p is ORed with a low mask.
    for (int k = 0; k < 4; k++) begin
      g = g | (p & (g << (1 << k)));
      p = p & ((p << (1 << k)) | ((16'd1 << (1 << k)) - 16'd1));
    end
    carry_bits = g | (p & {16{cin}});
    sum        = (a ^ b) ^ {carry_bits[14:0], cin};
    cout       = carry_bits[15];
  end
endmodule

module adder_multiword_seq #(
  parameter int CHUNK  = 16,
  parameter int CHUNKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHUNK*CHUNKS-1:0] a_in,
  input  logic [CHUNK*CHUNKS-1:0] b_in,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHUNK*CHUNKS-1:0] sum_out,
  output logic                    cout_out,
  output logic                    busy
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic                    ovf
`endif
);
  localparam int W     = CHUNK * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  // The datapath is hard-wired to the 16-bit adder instance.
  if (CHUNK != 16 || CHUNKS < 1 || CHUNKS > 16) begin : g_bad_params
    $error("adder_multiword_seq: CHUNK must be 16 and CHUNKS must be 1..16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_reg, b_reg, sum_reg;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               cout_reg;
  logic               accept;
  logic               last;
  logic [CHUNK-1:0]   add_a, add_b, add_sum;
  logic               add_cout;

  assign add_a  = a_reg[idx*CHUNK +: CHUNK];
  assign add_b  = b_reg[idx*CHUNK +: CHUNK];
  assign last   = (idx == LAST_IDX);
  assign accept = in_valid & in_ready;

  adder u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // in_ready depends combinationally on out_ready in DONE. This lets a result
  // retire and a new pair enter on the same edge.
  // NOTE: every always_comb output gets a default first so that no branch can
  // infer a latch.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: operand registers carry no reset. They are always loaded on accept
  // before they are read, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a_in;
      b_reg <= b_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= cin;
    end else if (state_q == RUN) begin
      sum_reg[idx*CHUNK +: CHUNK] <= add_sum;
      carry                       <= add_cout;
      idx                         <= idx + 1'b1;
      if (last) cout_reg <= add_cout;
    end
  end

`ifdef ADDER_SEQ_OVF_EN
  // On the last chunk, add_sum[CHUNK-1] is result bit W-1. The carry into the
  // MSB is recovered from the operand bits and that result bit.
  logic carry_into_msb;
  logic ovf_reg;
  assign carry_into_msb = a_reg[W-1] ^ b_reg[W-1] ^ add_sum[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst)                            ovf_reg <= 1'b0;
    else if (state_q == RUN && !accept && last) ovf_reg <= carry_into_msb ^ add_cout;
  end
  assign ovf = ovf_reg;
`endif

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = sum_reg;
  assign cout_out  = cout_reg;
endmodule

// File: tb/tb_adder_multiword_seq.sv
// -----------------------------------------------------------------------------
// tb_adder_multiword_seq
//   Directed bench for adder_multiword_seq with the default configuration
//   (CHUNK=16, CHUNKS=4, W=64). Inputs are driven and outputs are sampled 1 ns
//   after each rising edge. The ovf checks are present only when
//   ADDER_SEQ_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_adder_multiword_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in, b_in;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum_out;
  logic        cout_out;
  logic        busy;
`ifdef ADDER_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adder_multiword_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .busy      (busy)
`ifdef ADDER_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair while IDLE and waits for out_valid. cyc is the cycle index
  // where out_valid was first seen. Cycle 1 is the cycle right after the accept
  // edge. The wait is bounded at 20 cycles.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic c,
                       output int cyc);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, cout_out} !== 4'b1000 || sum_out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset: rdy/vld/busy/cout=%b sum=%h, want 1000 sum=0",
               {in_ready, out_valid, busy, cout_out}, sum_out);
    end
  endtask

  task automatic test_basic();
    int cyc;
    out_ready = 1'b0;
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, cyc);
    n_checks++;
    if (cyc !== 5) begin
      n_fail++; $display("FAIL basic_latency: out_valid in cycle %0d, want 5", cyc);
    end
    n_checks++;
    if (sum_out !== 64'h0000_0000_0001_0000 || cout_out !== 1'b0) begin
      n_fail++; $display("FAIL basic_sum: got %h/%b want 0000000000010000/0", sum_out, cout_out);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || sum_out !== 64'h0000_0000_0001_0000) begin
      n_fail++; $display("FAIL basic_idle_hold: vld/busy/rdy=%b sum=%h", {out_valid, busy, in_ready}, sum_out);
    end
  endtask

  task automatic test_ripple();
    int cyc;
    out_ready = 1'b0;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, cyc);
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 64'h0 || cout_out !== 1'b1) begin
      n_fail++; $display("FAIL ripple: vld=%b sum=%h cout=%b want 1/0/1", out_valid, sum_out, cout_out);
    end
`ifdef ADDER_SEQ_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL ripple_ovf: got %b want 0", ovf);
    end
`endif
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_signed_ovf();
    int cyc;
    out_ready = 1'b0;
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, cyc);
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 64'h8000_0000_0000_0000 || cout_out !== 1'b0) begin
      n_fail++; $display("FAIL signed: vld=%b sum=%h cout=%b want 1/8000000000000000/0", out_valid, sum_out, cout_out);
    end
`ifdef ADDER_SEQ_OVF_EN
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL signed_ovf: got %b want 1", ovf);
    end
`endif
    out_ready = 1'b1;
    tick();
  endtask

  // Operands for the second pair are presented during RUN. They must be ignored
  // until the first result retires.
  task automatic test_backpressure();
    int cyc;
    out_ready = 1'b0;
    a_in = 64'h1234_5678_9ABC_DEF0; b_in = 64'hFEDC_BA98_7654_3210; cin = 1'b1; in_valid = 1'b1;
    tick();
    a_in = 64'h0000_0000_0000_0005; b_in = 64'h0000_0000_0000_0006; cin = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL run_ignore: in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    // 1234..DEF0 + FEDC..3210 + 1 = 1_1111_1111_1111_1101
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({out_valid, in_ready, busy, cout_out} !== 4'b1011 || sum_out !== 64'h1111_1111_1111_1101) begin
        n_fail++; $display("FAIL hold[%0d]: vld/rdy/busy/cout=%b sum=%h", i, {out_valid, in_ready, busy, cout_out}, sum_out);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL retire_accept: vld=%b busy=%b want 0/1", out_valid, busy);
    end
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 64'hB || cout_out !== 1'b0) begin
      n_fail++; $display("FAIL second_op: vld=%b sum=%h cout=%b want 1/b/0", out_valid, sum_out, cout_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [64:0] prev_exp;
    logic [63:0] na, nb;
    logic        nc;
    int          w;
    out_ready = 1'b1;
    prev_exp  = '0;
    for (int i = 0; i < 100; i++) begin
      na = {$urandom(), $urandom()};
      nb = {$urandom(), $urandom()};
      nc = 1'($urandom_range(0, 1));
      if (i == 1) begin na = '1; nb = '1; nc = 1'b1; end
      a_in = na; b_in = nb; cin = nc; in_valid = 1'b1;
      if (i > 0) begin
        w = 0;
        while (!out_valid && w < 20) begin
          tick();
          w++;
        end
        n_checks++;
        if (w !== 4 || in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_timing[%0d]: waited %0d in_ready=%b want 4/1", i, w, in_ready);
        end
        n_checks++;
        if ({cout_out, sum_out} !== prev_exp) begin
          n_fail++; $display("FAIL b2b_sum[%0d]: got %b_%h want %h", i, cout_out, sum_out, prev_exp);
        end
      end
      tick();
      prev_exp = {1'b0, na} + {1'b0, nb} + {64'h0, nc};
    end
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      tick();
      w++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || {cout_out, sum_out} !== prev_exp) begin
      n_fail++; $display("FAIL b2b_last: vld=%b got %b_%h want %h", out_valid, cout_out, sum_out, prev_exp);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int cyc;
    out_ready = 1'b1;
    a_in = '1; b_in = '1; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, cout_out} !== 4'b1000 || sum_out !== 64'h0) begin
      n_fail++; $display("FAIL abort: rdy/vld/busy/cout=%b sum=%h want 1000 sum=0",
                         {in_ready, out_valid, busy, cout_out}, sum_out);
    end
    out_ready = 1'b0;
    issue(64'h3, 64'h4, 1'b0, cyc);
    n_checks++;
    if (out_valid !== 1'b1 || cyc !== 5 || sum_out !== 64'h7 || cout_out !== 1'b0) begin
      n_fail++; $display("FAIL after_abort: vld=%b cyc=%0d sum=%h cout=%b want 1/5/7/0", out_valid, cyc, sum_out, cout_out);
    end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ripple();
    test_signed_ovf();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
